qtps_issue_arbiter: RTL

Instruction issue controller in front of the single-issue QTPS core. Arbitrates up to NREQ instruction sources round-robin and buffers accepted words in a small FIFO. Drives exactly one registered instruction (or NOP) into the core per cycle. Halts on a core illegal-instruction flag, captures the faulting word and source, and holds until software clears the halt.

---
 rtl/qtps_issue_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/qtps_issue_arbiter.sv
// ---------------------------------------------------------------------------
// qtps_issue_arbiter
//
// Issue controller in front of the single-issue QTPS core. Up to NREQ
// instruction sources are arbitrated round-robin, and accepted words are
// buffered in a DEPTH-entry FIFO. The FIFO head is popped into a registered
// core_instr each cycle, or NOP_WORD is driven when nothing is issued. An
// illegal-instruction flag from the core on a real issue puts the controller
// into HALT. HALT captures the faulting word and its source, and lasts until
// halt_clr.
//
// Optional feature macro: QTPS_ISSUE_PERF_EN adds saturating performance
// counters (perf_issued, perf_stall, perf_illegal). They are cleared by
// flush.
//
// Parameters:
//   NREQ      number of requesters (2..4)
//   DEPTH     issue FIFO depth (power of two, >= 2)
//   NOP_WORD  word driven to the core when nothing is issued
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-requester instruction valid
//   req_instr      per-requester word, requester i at [32i+31:32i]
//   req_ready      per-requester accept (one-hot or zero)
//   core_instr     registered instruction into the core
//   core_status    core status word
//   core_illegal   core illegal flag for the current core_instr
//   issued_valid   core_instr carries a real instruction this cycle
//   issued_src     source index of the current core_instr
//   status_q       last core_status seen for a legal issued instruction
//   halted         controller is in HALT
//   err_src        source of the last faulting instruction
//   err_instr      last faulting instruction word
//   halt_clr       single-cycle pulse that leaves HALT
//   flush          discard the FIFO contents
//   fifo_count     FIFO occupancy, 0..DEPTH
//   perf_*         (QTPS_ISSUE_PERF_EN only) saturating event counters
// ---------------------------------------------------------------------------
module qtps_issue_arbiter #(
   parameter int          NREQ     = 2,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*32-1:0]      req_instr,
   output logic [NREQ-1:0]         req_ready,
   output logic [31:0]             core_instr,
   input  logic [31:0]             core_status,
   input  logic                    core_illegal,
   output logic                    issued_valid,
   output logic [$clog2(NREQ)-1:0] issued_src,
   output logic [31:0]             status_q,
   output logic                    halted,
   output logic [$clog2(NREQ)-1:0] err_src,
   output logic [31:0]             err_instr,
   input  logic                    halt_clr,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  fifo_count
`ifdef QTPS_ISSUE_PERF_EN
   ,
   output logic [31:0]             perf_issued,
   output logic [31:0]             perf_stall,
   output logic [15:0]             perf_illegal
`endif
);

   localparam int SRC_W = $clog2(NREQ);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = SRC_W + 32;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [SRC_W:0]   NREQ_C  = (SRC_W + 1)'(NREQ);
   localparam logic [SRC_W:0]   SRC_ONE = (SRC_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Control state
   state_t               state_q, state_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [SRC_W-1:0]     rr_q, rr_d;

   // Issue stage registers
   logic [31:0]          core_instr_q, core_instr_d;
   logic                 issued_valid_q, issued_valid_d;
   logic [SRC_W-1:0]     issued_src_q, issued_src_d;
   logic [31:0]          status_d;
   logic [SRC_W-1:0]     err_src_q, err_src_d;
   logic [31:0]          err_instr_q, err_instr_d;

   // FIFO storage: {source, instruction}, data only, no reset
   logic [ENT_W-1:0]     fifo_mem_q [DEPTH];
   logic [ENT_W-1:0]     head_ent;
   logic [SRC_W-1:0]     head_src;
   logic [31:0]          head_instr;

   // Handshake / arbitration
   logic                 running;
   logic                 illegal_hit;
   logic                 pop;
   logic                 room;
   logic                 grant_ok;
   logic                 grant_found;
   logic [SRC_W-1:0]     grant_idx;
   logic [SRC_W:0]       cand;
   logic [SRC_W:0]       rr_nxt;
   logic                 push;
   logic [31:0]          push_instr;

   assign running     = (state_q == ST_RUN);
   assign illegal_hit = issued_valid_q && core_illegal;

   assign head_ent   = fifo_mem_q[rd_ptr_q];
   assign head_src   = head_ent[ENT_W-1:32];
   assign head_instr = head_ent[31:0];

   // A faulting issue blocks the pop on its own edge, so the faulting word is
   // the last one the core sees before HALT.
   assign pop = running && (count_q != '0) && !flush && !illegal_hit;

   // A full FIFO still takes a word when the head leaves on the same edge.
   // This sustains one instruction per cycle.
   assign room = (count_q != DEPTH_C) || pop;

   // rst_n gating keeps req_ready low for the whole time reset is asserted.
   assign grant_ok = rst_n && running && !flush && room;

   // Round-robin search: the first valid requester at or after rr_q, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_q} + (SRC_W + 1)'(k);
         if (cand >= NREQ_C) begin
            cand = cand - NREQ_C;
         end
         if (!grant_found && req_valid[cand[SRC_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[SRC_W-1:0];
         end
      end
   end

   assign push       = grant_found && grant_ok;
   assign push_instr = req_instr[grant_idx*32 +: 32];

   always_comb begin
      req_ready = '0;
      if (push) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_nxt = {1'b0, grant_idx} + SRC_ONE;
      if (rr_nxt >= NREQ_C) begin
         rr_nxt = '0;
      end
      rr_d = push ? rr_nxt[SRC_W-1:0] : rr_q;
   end

   // Next-state and issue logic
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      core_instr_d   = NOP_WORD;
      issued_valid_d = 1'b0;
      issued_src_d   = issued_src_q;
      status_d       = status_q;
      err_src_d      = err_src_q;
      err_instr_d    = err_instr_q;

      // FIFO bookkeeping; flush wins over push and pop
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      if (pop) begin
         core_instr_d   = head_instr;
         issued_valid_d = 1'b1;
         issued_src_d   = head_src;
      end

      // The instruction currently at the core completes even under flush.
      if (issued_valid_q && !core_illegal) begin
         status_d = core_status;
      end

      case (state_q)
         ST_RUN: begin
            if (illegal_hit) begin
               state_d     = ST_HALT;
               err_src_d   = issued_src_q;
               err_instr_d = core_instr_q;
            end
         end
         ST_HALT: begin
            if (halt_clr) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_RUN;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rr_q           <= '0;
         core_instr_q   <= NOP_WORD;
         issued_valid_q <= 1'b0;
         issued_src_q   <= '0;
         status_q       <= '0;
         err_src_q      <= '0;
         err_instr_q    <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         rr_q           <= rr_d;
         core_instr_q   <= core_instr_d;
         issued_valid_q <= issued_valid_d;
         issued_src_q   <= issued_src_d;
         status_q       <= status_d;
         err_src_q      <= err_src_d;
         err_instr_q    <= err_instr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {grant_idx, push_instr};
      end
   end

   assign core_instr   = core_instr_q;
   assign issued_valid = issued_valid_q;
   assign issued_src   = issued_src_q;
   assign halted       = (state_q == ST_HALT);
   assign err_src      = err_src_q;
   assign err_instr    = err_instr_q;
   assign fifo_count   = count_q;

`ifdef QTPS_ISSUE_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [15:0] perf_illegal_q, perf_illegal_d;

   // Saturating counters; flush clears them and takes priority over counting.
   always_comb begin
      perf_issued_d  = perf_issued_q;
      perf_stall_d   = perf_stall_q;
      perf_illegal_d = perf_illegal_q;
      if (flush) begin
         perf_issued_d  = '0;
         perf_stall_d   = '0;
         perf_illegal_d = '0;
      end else begin
         if (issued_valid_q && !core_illegal && (perf_issued_q != '1)) begin
            perf_issued_d = perf_issued_q + 32'd1;
         end
         if ((|req_valid) && !push && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
         end
         if (illegal_hit && (perf_illegal_q != '1)) begin
            perf_illegal_d = perf_illegal_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued_q  <= '0;
         perf_stall_q   <= '0;
         perf_illegal_q <= '0;
      end else begin
         perf_issued_q  <= perf_issued_d;
         perf_stall_q   <= perf_stall_d;
         perf_illegal_q <= perf_illegal_d;
      end
   end

   assign perf_issued  = perf_issued_q;
   assign perf_stall   = perf_stall_q;
   assign perf_illegal = perf_illegal_q;
`endif

endmodule
